// File: rtl/adc_decimator_pkg.sv
// Shared widths, full-scale codes and the decimation-factor clamp for the
// dual-channel ADC boxcar decimator.
package adc_decimator_pkg;

   localparam int ADC_W             = 16;
   localparam int LOG2_MAX_DEC_DFLT = 10;
   localparam int ACC_W             = ADC_W + LOG2_MAX_DEC_DFLT;

   // Full-scale codes produced by the upstream extractor (low 2 bits always 0)
   localparam logic [ADC_W-1:0] ADC_POS_FS = 16'h7FFC;
   localparam logic [ADC_W-1:0] ADC_NEG_FS = 16'h8000;

   typedef logic [3:0] k_t;

   function automatic k_t clamp_k(input k_t req, input k_t kmax);
      return (req > kmax) ? kmax : req;
   endfunction

endpackage

// File: rtl/adc_accumulator.sv
// One channel of the decimator: running sum, shifted average register and
// full-scale code detection.
module adc_accumulator
   import adc_decimator_pkg::*;
#(
   parameter int LOG2_MAX_DEC = LOG2_MAX_DEC_DFLT
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [ADC_W-1:0] sample_i,
   input  logic             enable_i,
   input  logic             last_i,
   input  k_t               k_i,
   output logic [ADC_W-1:0] avg_o,
   output logic             fs_hit_o
);

   localparam int AW = ADC_W + LOG2_MAX_DEC;

   logic signed [AW-1:0] acc_q;
   logic signed [AW-1:0] sum;

   // 2^LOG2_MAX_DEC sign-extended samples cannot overflow AW bits
   assign sum = acc_q + $signed({{LOG2_MAX_DEC{sample_i[ADC_W-1]}}, sample_i});

   assign fs_hit_o = (sample_i == ADC_POS_FS) || (sample_i == ADC_NEG_FS);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         acc_q <= '0;
         avg_o <= '0;
      end else if (enable_i) begin
         if (last_i) begin
            acc_q <= '0;
            // Arithmetic shift floors toward -inf; the average always fits in ADC_W
            avg_o <= ADC_W'(sum >>> k_i);
         end else begin
            acc_q <= sum;
         end
      end
   end

endmodule

// File: rtl/adc_decimator.sv
// Dual-channel power-of-two boxcar decimator with a one-cycle valid strobe
// and a sticky full-scale clip flag.
module adc_decimator
   import adc_decimator_pkg::*;
#(
   parameter int LOG2_MAX_DEC = LOG2_MAX_DEC_DFLT
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [ADC_W-1:0] adcA_i,
   input  logic [ADC_W-1:0] adcB_i,
   input  logic             enable_i,
   input  logic [3:0]       log2_dec_i,
   input  logic             clip_clr_i,
   output logic [ADC_W-1:0] avgA_o,
   output logic [ADC_W-1:0] avgB_o,
   output logic             valid_o,
   output logic             clip_o
);

   logic [LOG2_MAX_DEC-1:0] cnt_q;
   logic [LOG2_MAX_DEC-1:0] last_cnt;
   k_t                      k_q;
   k_t                      k_cur;
   logic                    last;
   logic                    hit_a;
   logic                    hit_b;

   // The first sample of a window must already use the new k, otherwise a
   // k=0 window could never close on its only sample.
   assign k_cur    = (cnt_q == '0) ? clamp_k(log2_dec_i, k_t'(LOG2_MAX_DEC)) : k_q;
   assign last_cnt = ~({LOG2_MAX_DEC{1'b1}} << k_cur);
   assign last     = enable_i && (cnt_q == last_cnt);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q   <= '0;
         k_q     <= '0;
         valid_o <= 1'b0;
         clip_o  <= 1'b0;
      end else begin
         valid_o <= last;
         if (enable_i) begin
            if (cnt_q == '0) k_q <= k_cur;
            cnt_q <= last ? '0 : cnt_q + 1'b1;
         end
         // A new full-scale event outranks a simultaneous clear
         if (enable_i && (hit_a || hit_b)) clip_o <= 1'b1;
         else if (clip_clr_i)              clip_o <= 1'b0;
      end
   end

   adc_accumulator #(.LOG2_MAX_DEC(LOG2_MAX_DEC)) u_acc_a (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .sample_i (adcA_i),
      .enable_i (enable_i),
      .last_i   (last),
      .k_i      (k_cur),
      .avg_o    (avgA_o),
      .fs_hit_o (hit_a)
   );

   adc_accumulator #(.LOG2_MAX_DEC(LOG2_MAX_DEC)) u_acc_b (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .sample_i (adcB_i),
      .enable_i (enable_i),
      .last_i   (last),
      .k_i      (k_cur),
      .avg_o    (avgB_o),
      .fs_hit_o (hit_b)
   );

endmodule

// File: tb/tb_adc_decimator.sv
// Directed self-checking bench for adc_decimator with hand-computed averages.
module tb_adc_decimator;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic [15:0] adcA_i;
   logic [15:0] adcB_i;
   logic        enable_i;
   logic [3:0]  log2_dec_i;
   logic        clip_clr_i;
   logic [15:0] avgA_o;
   logic [15:0] avgB_o;
   logic        valid_o;
   logic        clip_o;

   int passed = 0;
   int total  = 0;
   int vcnt   = 0;

   always #5 clk_i = ~clk_i;

   adc_decimator dut (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .adcA_i     (adcA_i),
      .adcB_i     (adcB_i),
      .enable_i   (enable_i),
      .log2_dec_i (log2_dec_i),
      .clip_clr_i (clip_clr_i),
      .avgA_o     (avgA_o),
      .avgB_o     (avgB_o),
      .valid_o    (valid_o),
      .clip_o     (clip_o)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total = total + 1;
      assert (obs === exp) passed = passed + 1;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // One clock: drive inputs, wait for the edge, settle, tally valid strobes
   task automatic cyc(input logic en, input logic [15:0] a, input logic [15:0] b,
                      input logic clr = 1'b0);
      enable_i   = en;
      adcA_i     = a;
      adcB_i     = b;
      clip_clr_i = clr;
      @(posedge clk_i);
      #1;
      if (valid_o) vcnt = vcnt + 1;
   endtask

   initial begin
      rst_i      = 1'b1;
      adcA_i     = '0;
      adcB_i     = '0;
      enable_i   = 1'b0;
      log2_dec_i = 4'd2;
      clip_clr_i = 1'b0;
      repeat (2) @(posedge clk_i);
      #1;
      check("rst_avgA",  32'(avgA_o),  32'h0);
      check("rst_avgB",  32'(avgB_o),  32'h0);
      check("rst_valid", 32'(valid_o), 32'h0);
      check("rst_clip",  32'(clip_o),  32'h0);
      rst_i = 1'b0;

      // k=2: 4,8,12,16 -> 40/4 = 10
      vcnt = 0;
      cyc(1, 16'd4, 0);
      cyc(1, 16'd8, 0);
      cyc(1, 16'd12, 0);
      check("k2_no_early_valid", 32'(vcnt), 32'd0);
      cyc(1, 16'd16, 0);
      check("k2_valid",  32'(valid_o), 32'h1);
      check("k2_avgA",   32'(avgA_o),  32'h000A);
      check("k2_avgB",   32'(avgB_o),  32'h0000);
      cyc(0, 16'd99, 16'd99);
      check("k2_valid_1cyc", 32'(valid_o), 32'h0);
      check("k2_avgA_hold",  32'(avgA_o),  32'h000A);

      // k=0 pass-through on channel B
      log2_dec_i = 4'd0;
      cyc(1, 0, 16'hFFFC);
      check("k0_valid0", 32'(valid_o), 32'h1);
      check("k0_avgB0",  32'(avgB_o),  32'hFFFC);
      cyc(1, 0, 16'h0028);
      check("k0_valid1", 32'(valid_o), 32'h1);
      check("k0_avgB1",  32'(avgB_o),  32'h0028);

      // k=1: sums -4, -4, -6 -> -2, -2, -3 (floor)
      log2_dec_i = 4'd1;
      cyc(1, 16'hFFFC, 0);
      cyc(1, 16'h0000, 0);
      check("k1_a_avg", 32'(avgA_o), 32'hFFFE);
      cyc(1, 16'hFFF8, 0);
      cyc(1, 16'h0004, 0);
      check("k1_b_avg", 32'(avgA_o), 32'hFFFE);
      cyc(1, 16'hFFFE, 0);
      cyc(1, 16'hFFFC, 0);
      check("k1_floor_avg", 32'(avgA_o), 32'hFFFD);
      // k=2: -4/4 = -1 exactly; also -4,0,0,0 at k=2 floors to -1 not 0
      log2_dec_i = 4'd2;
      cyc(1, 16'hFFFC, 0);
      cyc(1, 0, 0);
      cyc(1, 0, 0);
      cyc(1, 0, 16'h0004);
      check("k2_neg_avgA", 32'(avgA_o), 32'hFFFF);
      check("k2_small_avgB", 32'(avgB_o), 32'h0001);

      // Requested k=15 clamps to 10: 1024 positive full-scale samples
      log2_dec_i = 4'd15;
      vcnt = 0;
      cyc(1, 16'h7FFC, 0);
      check("fs_clip_set", 32'(clip_o), 32'h1);
      for (int i = 1; i < 1023; i++) cyc(1, 16'h7FFC, 0);
      check("fs_no_early_valid", 32'(vcnt), 32'd0);
      cyc(1, 16'h7FFC, 0);
      check("fs_valid", 32'(valid_o), 32'h1);
      check("fs_avgA",  32'(avgA_o),  32'h7FFC);
      cyc(0, 0, 0);
      check("clip_sticky", 32'(clip_o), 32'h1);
      cyc(0, 0, 0, 1'b1);
      check("clip_clear", 32'(clip_o), 32'h0);
      log2_dec_i = 4'd0;
      cyc(1, 16'h8000, 0, 1'b1);
      check("clip_set_wins", 32'(clip_o), 32'h1);
      check("neg_fs_avgA",   32'(avgA_o), 32'h8000);
      cyc(0, 0, 0, 1'b1);
      check("clip_clear2", 32'(clip_o), 32'h0);

      // k=3 with gated enable; full-scale junk on idle cycles must be ignored
      log2_dec_i = 4'd3;
      vcnt = 0;
      for (int i = 1; i <= 8; i++) begin
         cyc(1, 16'(8 * i), 0);
         if (i == 8) check("gated_valid", 32'(valid_o), 32'h1);
         cyc(0, 16'h7FFC, 16'h8000);
      end
      check("gated_vcnt", 32'(vcnt),   32'd1);
      check("gated_avgA", 32'(avgA_o), 32'h0024);
      check("gated_clip", 32'(clip_o), 32'h0);

      // k changes 3->1 mid-window: window still 8 samples, next one 2
      vcnt = 0;
      for (int i = 0; i < 3; i++) cyc(1, 16'd8, 0);
      log2_dec_i = 4'd1;
      for (int i = 0; i < 4; i++) cyc(1, 16'd8, 0);
      check("kchg_no_early_valid", 32'(vcnt), 32'd0);
      cyc(1, 16'd8, 0);
      check("kchg_valid8", 32'(valid_o), 32'h1);
      check("kchg_avgA8",  32'(avgA_o),  32'h0008);
      cyc(1, 16'd20, 0);
      cyc(1, 16'd40, 0);
      check("kchg_valid2", 32'(valid_o), 32'h1);
      check("kchg_avgA2",  32'(avgA_o),  32'h001E);

      // Reset after 5 samples discards the partial window
      log2_dec_i = 4'd3;
      vcnt = 0;
      for (int i = 0; i < 5; i++) cyc(1, 16'd100, 16'h7FFC);
      check("mid_clip_before_rst", 32'(clip_o), 32'h1);
      rst_i = 1'b1;
      cyc(0, 0, 0);
      rst_i = 1'b0;
      check("mid_rst_vcnt",  32'(vcnt),    32'd0);
      check("mid_rst_avgA",  32'(avgA_o),  32'h0);
      check("mid_rst_valid", 32'(valid_o), 32'h0);
      check("mid_rst_clip",  32'(clip_o),  32'h0);
      for (int i = 0; i < 7; i++) cyc(1, 16'd12, 16'hFFF4);
      check("post_rst_no_early", 32'(vcnt), 32'd0);
      cyc(1, 16'd12, 16'hFFF4);
      check("post_rst_valid", 32'(valid_o), 32'h1);
      check("post_rst_avgA",  32'(avgA_o),  32'h000C);
      check("post_rst_avgB",  32'(avgB_o),  32'hFFF4);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/adc_decimator.md
# adc_decimator

Dual-channel decimating boxcar averager directly downstream of the ADC input extractor. It consumes the two signed 16-bit channel words, whose low 2 bits are always zero. Each channel is averaged over a programmable power-of-two window, and the block emits one averaged sample pair per window with a single-cycle valid strobe. It also keeps a sticky clipping flag so software can detect ADC full-scale events.

## Interface
Parameters:
- LOG2_MAX_DEC, default 10: largest supported log2 of the decimation factor. The accumulator width is 16+LOG2_MAX_DEC.

Ports:
- clk_i  in  1  ADC sample clock. The single clock domain for the block.
- rst_i  in  1  Synchronous, active-high reset.
- adcA_i  in  16  Channel A sample, signed two's complement.
- adcB_i  in  16  Channel B sample, signed two's complement.
- enable_i  in  1  Sample qualifier. A sample is consumed only on cycles where this is high.
- log2_dec_i  in  4  Requested k. The window length is N = 2^k.
- clip_clr_i  in  1  Clears the sticky clip flag.
- avgA_o  out  16  Channel A average, signed.
- avgB_o  out  16  Channel B average, signed.
- valid_o  out  1  One-cycle strobe marking new avgA_o/avgB_o values.
- clip_o  out  1  Sticky flag: a full-scale sample was seen.

## Operation
- Reset: avgA_o, avgB_o, valid_o and clip_o are all 0. Accumulators, the sample counter and the latched k are 0.
- Window start: when the counter is 0 and enable_i is high, latch k_eff = min(log2_dec_i, LOG2_MAX_DEC).
  - A change to log2_dec_i mid-window has no effect until the next window.
- Each enabled cycle:
  - sign-extend each sample to the accumulator width and add it;
  - increment the counter.
- Last sample of a window (counter == 2^k_eff − 1 with enable_i high):
  - compute the sum including the current sample;
  - register sum >>> k_eff into avg*_o. This is an arithmetic shift, so it truncates toward −infinity;
  - assert valid_o for one cycle;
  - load the accumulators with 0 and the counter with 0.
- enable_i low: the accumulators and counter hold, valid_o is 0, and avg*_o hold.
- k_eff = 0: pass-through. Every enabled sample appears on avg*_o one cycle later with valid_o high.
- Overflow: none is possible. 2^LOG2_MAX_DEC samples of at most 16 bits fit in the accumulator width. The shifted result always fits in 16 bits with no saturation.
- Clip detection: on an enabled cycle, clip_o is set if either channel equals 16'h8000 or 16'h7FFC (the extractor's full-scale codes).
  - clip_o holds until clip_clr_i is asserted.
  - If clip_clr_i and a clip event occur in the same cycle, the set wins.
- Reset mid-window discards the partial sums. No valid_o is produced for that window.

## Timing
- Latency: valid_o and the new avg*_o values appear on the clock edge after the cycle presenting the last sample of the window.
- avg*_o are stable from that edge until the next valid_o.
- Output period: exactly 2^k_eff enabled cycles. With continuous enable_i, valid_o fires every 2^k_eff clocks.
- clip_o: set takes one cycle (set the edge after the offending sample); clear takes one cycle (cleared the edge after clip_clr_i).
- There is no backpressure. The downstream stage must accept every valid_o strobe.

## Structure
- Shared package:
  - ADC_W = 16;
  - ACC_W = ADC_W + LOG2_MAX_DEC;
  - full-scale constants ADC_POS_FS = 16'h7FFC and ADC_NEG_FS = 16'h8000;
  - the k clamp function.
- Sub-module adc_accumulator, instantiated once per channel. It holds the accumulator, the shift-and-register output and the clip-compare output.
- The top level holds the shared counter, the k latch, the valid_o generation and the sticky clip register.

## Test plan
- Reset, then k=2 with continuous enable and A samples 4, 8, 12, 16 → exactly one valid_o, one cycle after the 4th sample, with avgA_o=10.
- k=0 with B samples −4, 40 → avgB_o=−4 then 40 on consecutive cycles, valid_o high both cycles, each output one cycle after its input.
- k=1 with A samples −4, 0 → avgA_o=−2. Then −4, −0 gives sum −4, so the output is −2. Then −8, 4 (sum −4) → −2. Also test sum −6 → −3, confirming truncation toward −infinity.
- k=10 with 1024 samples of 16'h7FFC → avgA_o=16'h7FFC and no overflow. clip_o is set and stays set until clip_clr_i. With clip_clr_i and a 16'h8000 sample in the same cycle, clip_o stays 1.
- k=3 with enable_i toggling every other cycle → valid_o only after 8 enabled samples (16 clocks), and the average covers only the enabled samples.
- log2_dec_i changes from 3 to 1 after 3 samples → the current window still closes after 8 samples, and the next window is 2 samples. Reset asserted after 5 samples of a window → no valid_o, all outputs 0, and the next window starts clean.
